// File: rtl/shift_rotate_unit.sv
// Single-bit shift/rotate unit for the 16-bit ALU datapath; result and carry-out registered.
// Build option: define SHIFT_SRA_EN to make op=01 an arithmetic (sign-filling) right shift.
module shift_rotate_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  op,
    input  logic [15:0] i0,
    output logic [15:0] o,
    output logic        co
);

    localparam int unsigned W = 16;

    logic         fill;
    logic [W-1:0] sll_src;
    logic [W-1:0] srl_src;
    logic [W-1:0] rol_src;
    logic [W-1:0] ror_src;
    logic [W-1:0] next_o;
    logic [3:0]   co_cand;
    logic         next_co;

    // Bit shifted into position 15 by a right shift
`ifdef SHIFT_SRA_EN
    assign fill = i0[W-1];
`else
    assign fill = 1'b0;
`endif

    // Candidate source for each result bit, one vector per op
    assign sll_src = {i0[W-2:0], 1'b0};
    assign srl_src = {fill, i0[W-1:1]};
    assign rol_src = {i0[W-2:0], i0[W-1]};
    assign ror_src = {i0[0], i0[W-1:1]};

    // Per-bit 4:1 mux indexed directly by op so an unknown op propagates as X
    for (genvar k = 0; k < W; k++) begin : g_bit
        logic [3:0] cand;
        assign cand      = {ror_src[k], rol_src[k], srl_src[k], sll_src[k]};
        assign next_o[k] = cand[op];
    end

    // Left ops expel bit 15, right ops expel bit 0
    assign co_cand = {i0[0], i0[W-1], i0[0], i0[W-1]};
    assign next_co = co_cand[op];

    always_ff @(posedge clk) begin
        if (reset) begin
            o  <= '0;
            co <= 1'b0;
        end else begin
            o  <= next_o;
            co <= next_co;
        end
    end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed table-driven bench for shift_rotate_unit, plus reset sequences.
module tb_shift_rotate_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  op;
    logic [15:0] i0;
    logic [15:0] o;
    logic        co;

    int checks;
    int errors;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] i0;
        logic [15:0] exp_o;
        logic        exp_co;
    } vec_t;

    vec_t vecs[$];

    shift_rotate_unit dut (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .i0    (i0),
        .o     (o),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic r, input logic [1:0] p, input logic [15:0] d);
        @(negedge clk);
        reset = r;
        op    = p;
        i0    = d;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] p, input logic [15:0] d,
                                input logic [15:0] eo, input logic ec);
        vec_t v;
        v.op = p; v.i0 = d; v.exp_o = eo; v.exp_co = ec;
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        op     = 2'b11;
        i0     = 16'hFFFF;

        vecs.push_back(mk(2'b00, 16'h55AA, 16'hAB54, 1'b0));
        vecs.push_back(mk(2'b00, 16'h8001, 16'h0002, 1'b1));
        vecs.push_back(mk(2'b00, 16'h8000, 16'h0000, 1'b1));
        vecs.push_back(mk(2'b00, 16'h0000, 16'h0000, 1'b0));
`ifdef SHIFT_SRA_EN
        vecs.push_back(mk(2'b01, 16'hAAAA, 16'hD555, 1'b0));
        vecs.push_back(mk(2'b01, 16'h7FFF, 16'h3FFF, 1'b1));
        vecs.push_back(mk(2'b01, 16'h8001, 16'hC000, 1'b1));
`else
        vecs.push_back(mk(2'b01, 16'h8001, 16'h4000, 1'b1));
        vecs.push_back(mk(2'b01, 16'hAAAA, 16'h5555, 1'b0));
        vecs.push_back(mk(2'b01, 16'h7FFF, 16'h3FFF, 1'b1));
`endif
        vecs.push_back(mk(2'b01, 16'h0001, 16'h0000, 1'b1));
        vecs.push_back(mk(2'b10, 16'h8001, 16'h0003, 1'b1));
        vecs.push_back(mk(2'b10, 16'h7FFF, 16'hFFFE, 1'b0));
        vecs.push_back(mk(2'b10, 16'hFFFF, 16'hFFFF, 1'b1));
        vecs.push_back(mk(2'b11, 16'h0001, 16'h8000, 1'b1));
        vecs.push_back(mk(2'b11, 16'h5555, 16'hAAAA, 1'b1));
        vecs.push_back(mk(2'b11, 16'h8000, 16'h4000, 1'b0));

        // Reset held for two edges with a non-zero operation presented
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 2'b11, 16'hFFFF);
            check16("reset_o", o, 16'h0000);
            check1("reset_co", co, 1'b0);
        end

        // First edge with reset low captures the presented op
        step(1'b0, 2'b11, 16'hFFFF);
        check16("post_reset_o", o, 16'hFFFF);
        check1("post_reset_co", co, 1'b1);

        // Back-to-back table: inputs change every cycle, each result one cycle later
        foreach (vecs[i]) begin
            step(1'b0, vecs[i].op, vecs[i].i0);
            check16($sformatf("vec%0d_o", i), o, vecs[i].exp_o);
            check1($sformatf("vec%0d_co", i), co, vecs[i].exp_co);
        end

        // Reset mid-stream has priority over a live operation
        step(1'b0, 2'b00, 16'h4001);
        check16("pre_midreset_o", o, 16'h8002);
        check1("pre_midreset_co", co, 1'b0);
        step(1'b1, 2'b00, 16'hFFFF);
        check16("midreset_o", o, 16'h0000);
        check1("midreset_co", co, 1'b0);
        step(1'b0, 2'b10, 16'h8001);
        check16("after_midreset_o", o, 16'h0003);
        check1("after_midreset_co", co, 1'b1);

        // Holding inputs steady keeps the same result each edge
        step(1'b0, 2'b10, 16'h8001);
        check16("hold_o", o, 16'h0003);
        check1("hold_co", co, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
